// File: rtl/uart_rx_if.sv
// Byte-stream interface of the UART receiver: serial line and ready in, byte with status out.
// The master modport is the receiver; the slave modport is the line driver and byte consumer.
interface uart_rx_if;
  logic       uart_bit_i;
  logic       ready_i;
  logic [7:0] uart_byte_o;
  logic       valid_o;
  logic       framing_err_o;
  logic       overrun_o;
  logic       busy_o;

  modport master (
    input  uart_bit_i,
    input  ready_i,
    output uart_byte_o,
    output valid_o,
    output framing_err_o,
    output overrun_o,
    output busy_o
  );

  modport slave (
    output uart_bit_i,
    output ready_i,
    input  uart_byte_o,
    input  valid_o,
    input  framing_err_o,
    input  overrun_o,
    input  busy_o
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a valid/ready byte output.
// Each byte is registered at mid-stop, so the receiver re-arms early enough for back-to-back frames.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic     clk_uart,
  input  logic     rst,
  uart_rx_if.master bus
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   rxs_s;
  state_t                 state_r, state_nxt_s;
  logic [CW-1:0]          cnt_r, cnt_nxt_s;
  logic [2:0]             bit_idx_r, bit_idx_nxt_s;
  logic [7:0]             shift_r, shift_nxt_s;
  logic                   deliver_s, frame_err_s;
  logic [7:0]             byte_r;
  logic                   valid_r, framing_err_r, overrun_r, busy_r;

  assign rxs_s = sync_r[SYNC_STAGES-1];

  // Synchroniser for the asynchronous serial line
  always_ff @(posedge clk_uart or posedge rst) begin
    if (rst) begin
      sync_r <= '1;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], bus.uart_bit_i};
    end
  end

  // FSM, counters and shift register state
  always_ff @(posedge clk_uart or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      bit_idx_r <= bit_idx_nxt_s;
      shift_r   <= shift_nxt_s;
    end
  end

  // Next-state logic and mid-bit sampling decisions
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    bit_idx_nxt_s = bit_idx_r;
    shift_nxt_s   = shift_r;
    deliver_s     = 1'b0;
    frame_err_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (!rxs_s) begin
          state_nxt_s = START;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == HALF_M1) begin
          cnt_nxt_s = '0;
          // A start bit that is gone by mid-bit was a glitch
          if (!rxs_s) begin
            state_nxt_s   = DATA;
            bit_idx_nxt_s = 3'd0;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_r == BIT_M1) begin
          cnt_nxt_s   = '0;
          shift_nxt_s = {rxs_s, shift_r[7:1]};
          if (bit_idx_r == 3'd7) begin
            state_nxt_s = STOP;
          end else begin
            bit_idx_nxt_s = bit_idx_r + 3'd1;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      STOP: begin
        if (cnt_r == BIT_M1) begin
          cnt_nxt_s = '0;
          if (rxs_s) begin
            deliver_s   = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            frame_err_s = 1'b1;
            state_nxt_s = WAIT_IDLE;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      WAIT_IDLE: begin
        if (rxs_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // Output byte, handshake and status pulses
  always_ff @(posedge clk_uart or posedge rst) begin
    if (rst) begin
      byte_r        <= 8'h00;
      valid_r       <= 1'b0;
      framing_err_r <= 1'b0;
      overrun_r     <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      if (deliver_s) begin
        byte_r  <= shift_r;
        valid_r <= 1'b1;
      end else if (valid_r && bus.ready_i) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
      framing_err_r <= frame_err_s;
      overrun_r     <= deliver_s & valid_r & ~bus.ready_i;
      busy_r        <= (state_nxt_s != IDLE);
    end
  end

  assign bus.uart_byte_o   = byte_r;
  assign bus.valid_o       = valid_r;
  assign bus.framing_err_o = framing_err_r;
  assign bus.overrun_o     = overrun_r;
  assign bus.busy_o        = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: clean frames, glitch, framing error, overrun, same-edge accept, mid-frame reset.
module tb_uart_rx;
  localparam int CPB  = 16;
  localparam int SYNC = 2;
  // Frame edge 0 is SYNC+1 clocks after the line falls; valid_o is set 152 clocks later
  localparam int LAT  = SYNC + 1 + CPB / 2 + 9 * CPB;

  logic clk_uart = 1'b0;
  logic rst      = 1'b1;
  always #5 clk_uart = ~clk_uart;

  uart_rx_if rx_bus ();

  uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
    .clk_uart (clk_uart),
    .rst      (rst),
    .bus      (rx_bus)
  );

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int valid_rises = 0, valid_cycles = 0, fe_cycles = 0, ov_cycles = 0, busy_cycles = 0;
  int last_rise_cyc = 0;
  logic [7:0] rise_byte = 8'h00;
  logic valid_prev = 1'b0;

  always @(posedge clk_uart) cyc <= cyc + 1;

  // Event counters sampled mid-cycle
  always @(negedge clk_uart) begin
    if (rx_bus.valid_o) begin
      valid_cycles <= valid_cycles + 1;
      if (!valid_prev) begin
        valid_rises   <= valid_rises + 1;
        last_rise_cyc <= cyc;
        rise_byte     <= rx_bus.uart_byte_o;
      end
    end
    valid_prev <= rx_bus.valid_o;
    if (rx_bus.framing_err_o) fe_cycles <= fe_cycles + 1;
    if (rx_bus.overrun_o) ov_cycles <= ov_cycles + 1;
    if (rx_bus.busy_o) busy_cycles <= busy_cycles + 1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_uart);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx_bus.uart_bit_i = 1'b1;
    step(n);
  endtask

  // Drives one frame; ready_i pulses high for the cycle index pulse_at when pulse_at >= 0
  task automatic send_frame(input logic [7:0] d, input logic stop, input int pulse_at);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int i = 0; i < 10 * CPB; i++) begin
      rx_bus.uart_bit_i = fr[i / CPB];
      if (pulse_at >= 0) begin
        if (i == pulse_at) rx_bus.ready_i = 1'b1;
        else if (i == pulse_at + 1) rx_bus.ready_i = 1'b0;
      end
      @(posedge clk_uart);
      #1;
    end
  endtask

  task automatic test_reset;
    rx_bus.uart_bit_i = 1'b1;
    rx_bus.ready_i = 1'b1;
    rst = 1'b1;
    step(3);
    total++; if (rx_bus.valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", rx_bus.valid_o); end
    total++; if (rx_bus.uart_byte_o !== 8'h00) begin bad++; $display("FAIL reset_byte got=%0h exp=00", rx_bus.uart_byte_o); end
    total++; if (rx_bus.framing_err_o !== 1'b0) begin bad++; $display("FAIL reset_fe got=%0b exp=0", rx_bus.framing_err_o); end
    total++; if (rx_bus.overrun_o !== 1'b0) begin bad++; $display("FAIL reset_ov got=%0b exp=0", rx_bus.overrun_o); end
    total++; if (rx_bus.busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", rx_bus.busy_o); end
    rst = 1'b0;
    idle(5);
  endtask

  task automatic test_frame_a5;
    int v0, vc0, fe0, t0;
    rx_bus.ready_i = 1'b1;
    v0 = valid_rises; vc0 = valid_cycles; fe0 = fe_cycles; t0 = cyc;
    send_frame(8'hA5, 1'b1, -1);
    idle(4);
    total++; if (valid_rises - v0 !== 1) begin bad++; $display("FAIL a5_rises got=%0d exp=1", valid_rises - v0); end
    total++; if (valid_cycles - vc0 !== 1) begin bad++; $display("FAIL a5_valid_width got=%0d exp=1", valid_cycles - vc0); end
    total++; if (last_rise_cyc - t0 !== LAT) begin bad++; $display("FAIL a5_latency got=%0d exp=%0d", last_rise_cyc - t0, LAT); end
    total++; if (rise_byte !== 8'hA5) begin bad++; $display("FAIL a5_byte got=%0h exp=a5", rise_byte); end
    total++; if (fe_cycles - fe0 !== 0) begin bad++; $display("FAIL a5_fe got=%0d exp=0", fe_cycles - fe0); end
    total++; if (rx_bus.busy_o !== 1'b0) begin bad++; $display("FAIL a5_busy got=%0b exp=0", rx_bus.busy_o); end
  endtask

  task automatic test_glitch;
    int v0, fe0, b0;
    v0 = valid_rises; fe0 = fe_cycles; b0 = busy_cycles;
    rx_bus.uart_bit_i = 1'b0;
    step(4);
    idle(30);
    total++; if (busy_cycles - b0 !== CPB / 2) begin bad++; $display("FAIL glitch_busy got=%0d exp=%0d", busy_cycles - b0, CPB / 2); end
    total++; if (valid_rises - v0 !== 0) begin bad++; $display("FAIL glitch_valid got=%0d exp=0", valid_rises - v0); end
    total++; if (fe_cycles - fe0 !== 0) begin bad++; $display("FAIL glitch_fe got=%0d exp=0", fe_cycles - fe0); end
  endtask

  task automatic test_framing;
    int v0, fe0;
    v0 = valid_rises; fe0 = fe_cycles;
    send_frame(8'h3C, 1'b0, -1);
    rx_bus.uart_bit_i = 1'b0;
    step(40);
    total++; if (fe_cycles - fe0 !== 1) begin bad++; $display("FAIL fe_pulse got=%0d exp=1", fe_cycles - fe0); end
    total++; if (valid_rises - v0 !== 0) begin bad++; $display("FAIL fe_valid got=%0d exp=0", valid_rises - v0); end
    total++; if (rx_bus.busy_o !== 1'b1) begin bad++; $display("FAIL fe_wait_idle_busy got=%0b exp=1", rx_bus.busy_o); end
    idle(10);
    total++; if (rx_bus.busy_o !== 1'b0) begin bad++; $display("FAIL fe_rearm_busy got=%0b exp=0", rx_bus.busy_o); end
    send_frame(8'h11, 1'b1, -1);
    idle(4);
    total++; if (valid_rises - v0 !== 1) begin bad++; $display("FAIL fe_next_rises got=%0d exp=1", valid_rises - v0); end
    total++; if (rise_byte !== 8'h11) begin bad++; $display("FAIL fe_next_byte got=%0h exp=11", rise_byte); end
    total++; if (fe_cycles - fe0 !== 1) begin bad++; $display("FAIL fe_next_fe got=%0d exp=1", fe_cycles - fe0); end
  endtask

  task automatic test_overrun;
    int v0, ov0;
    rx_bus.ready_i = 1'b0;
    v0 = valid_rises; ov0 = ov_cycles;
    send_frame(8'h12, 1'b1, -1);
    total++; if (rx_bus.valid_o !== 1'b1) begin bad++; $display("FAIL ov_first_valid got=%0b exp=1", rx_bus.valid_o); end
    total++; if (rx_bus.uart_byte_o !== 8'h12) begin bad++; $display("FAIL ov_first_byte got=%0h exp=12", rx_bus.uart_byte_o); end
    send_frame(8'h5A, 1'b1, -1);
    total++; if (rx_bus.uart_byte_o !== 8'h5A) begin bad++; $display("FAIL ov_second_byte got=%0h exp=5a", rx_bus.uart_byte_o); end
    total++; if (rx_bus.valid_o !== 1'b1) begin bad++; $display("FAIL ov_second_valid got=%0b exp=1", rx_bus.valid_o); end
    total++; if (ov_cycles - ov0 !== 1) begin bad++; $display("FAIL ov_pulse got=%0d exp=1", ov_cycles - ov0); end
    total++; if (valid_rises - v0 !== 1) begin bad++; $display("FAIL ov_rises got=%0d exp=1", valid_rises - v0); end
    rx_bus.ready_i = 1'b1;
    step(1);
    total++; if (rx_bus.valid_o !== 1'b0) begin bad++; $display("FAIL ov_accept_clear got=%0b exp=0", rx_bus.valid_o); end
    idle(4);
  endtask

  task automatic test_back_to_back_accept;
    int v0, ov0;
    rx_bus.ready_i = 1'b0;
    send_frame(8'h33, 1'b1, -1);
    total++; if (rx_bus.uart_byte_o !== 8'h33) begin bad++; $display("FAIL same_edge_old_byte got=%0h exp=33", rx_bus.uart_byte_o); end
    v0 = valid_rises; ov0 = ov_cycles;
    send_frame(8'h7E, 1'b1, LAT - 1);
    total++; if (rx_bus.valid_o !== 1'b1) begin bad++; $display("FAIL same_edge_valid got=%0b exp=1", rx_bus.valid_o); end
    total++; if (rx_bus.uart_byte_o !== 8'h7E) begin bad++; $display("FAIL same_edge_byte got=%0h exp=7e", rx_bus.uart_byte_o); end
    total++; if (ov_cycles - ov0 !== 0) begin bad++; $display("FAIL same_edge_ov got=%0d exp=0", ov_cycles - ov0); end
    total++; if (valid_rises - v0 !== 0) begin bad++; $display("FAIL same_edge_rises got=%0d exp=0", valid_rises - v0); end
    rx_bus.ready_i = 1'b1;
    step(1);
    total++; if (rx_bus.valid_o !== 1'b0) begin bad++; $display("FAIL same_edge_clear got=%0b exp=0", rx_bus.valid_o); end
    idle(4);
  endtask

  task automatic test_reset_midframe;
    int v0;
    rx_bus.ready_i = 1'b1;
    v0 = valid_rises;
    fork
      send_frame(8'hFF, 1'b1, -1);
      begin
        // Line is in data bit 4 at frame cycle 85
        repeat (85) @(posedge clk_uart);
        #3;
        total++; if (rx_bus.busy_o !== 1'b1) begin bad++; $display("FAIL rst_pre_busy got=%0b exp=1", rx_bus.busy_o); end
        #1 rst = 1'b1;
        #1;
        total++; if (rx_bus.busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", rx_bus.busy_o); end
        total++; if (rx_bus.uart_byte_o !== 8'h00) begin bad++; $display("FAIL rst_byte got=%0h exp=00", rx_bus.uart_byte_o); end
        total++; if (rx_bus.valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", rx_bus.valid_o); end
        #2 rst = 1'b0;
      end
    join
    idle(4);
    total++; if (valid_rises - v0 !== 0) begin bad++; $display("FAIL rst_no_delivery got=%0d exp=0", valid_rises - v0); end
    send_frame(8'h81, 1'b1, -1);
    idle(4);
    total++; if (valid_rises - v0 !== 1) begin bad++; $display("FAIL rst_next_rises got=%0d exp=1", valid_rises - v0); end
    total++; if (rise_byte !== 8'h81) begin bad++; $display("FAIL rst_next_byte got=%0h exp=81", rise_byte); end
  endtask

  initial begin
    test_reset;
    test_frame_a5;
    test_glitch;
    test_framing;
    test_overrun;
    test_back_to_back_accept;
    test_reset_midframe;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
